mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the core's single backing-memory port between the instruction-cache refill path and the data-cache refill/write-back path. It accepts one request at a time, issues it on the memory port, waits for completion, and returns the result to the owning requester. One transaction is in flight at any time. The arbiter sits between the caches and the external memory interface, below the `icache_*` and `dcache_*` ports of the core.

## Interface
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 128: transfer width, one cache line.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `ic_req_valid`  in  1  icache read request.
- `ic_req_addr`  in  ADDR_W  icache request address.
- `ic_req_ready`  out  1  icache request accepted this cycle.
- `ic_resp_valid`  out  1  one-cycle pulse; icache read data valid.
- `ic_resp_data`  out  DATA_W  icache read data.
- `dc_req_valid`  in  1  dcache request.
- `dc_req_addr`  in  ADDR_W  dcache request address.
- `dc_req_we`  in  1  1 = write, 0 = read.
- `dc_req_wdata`  in  DATA_W  dcache write data.
- `dc_req_ready`  out  1  dcache request accepted this cycle.
- `dc_resp_valid`  out  1  one-cycle pulse; read data valid, or write complete.
- `dc_resp_data`  out  DATA_W  dcache read data.
- `mem_req_valid`  out  1  memory request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  ADDR_W  memory address.
- `mem_req_we`  out  1  memory write.
- `mem_req_wdata`  out  DATA_W  memory write data.
- `mem_resp_valid`  in  1  memory read data valid.
- `mem_resp_data`  in  DATA_W  memory read data.
- `busy`  out  1  1 when the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant is computed combinationally from the valid inputs.
  - Only the granted requester sees `*_req_ready = 1`; the other sees 0.
  - On a handshake, latch addr, we and wdata plus an owner bit, then go to ISSUE.
  - icache requests always latch we = 0.
- **ISSUE:**
  - `mem_req_valid = 1`; the latched fields are driven and held stable.
  - On `mem_req_ready`: a write goes to RESP, a read goes to WAIT.
- **WAIT:** on `mem_resp_valid`, capture `mem_resp_data` into the response register, then go to RESP.
- **RESP:**
  - The owner's `*_resp_valid = 1` for exactly one cycle.
  - `*_resp_data` presents the registered data; it is don't-care for a write response.
  - Then return to IDLE.
- **Requester rules:** hold valid and payload stable until ready. Drop valid after the handshake, or issue the next request no earlier than the resp pulse.
- **Stray memory responses:** `mem_resp_valid` outside WAIT is ignored, with no state change.
- **Default priority:** fixed, dcache wins when both requesters are valid.
- **`busy`:** equals (state != IDLE).

## Timing
- **Reset values:**
  - All `*_ready`, `*_resp_valid`, `mem_req_valid`, `mem_req_we` and `busy` are 0.
  - Data and address outputs are 0.
  - State is IDLE; `last_owner` is icache.
- **Reset mid-transaction:** abort to IDLE immediately with no response pulse. A late `mem_resp_valid` is then discarded.
- **Request handshake in cycle t:**
  - `mem_req_valid` is high from t+1.
  - Write accepted at t+1: `dc_resp_valid` at t+2.
  - Read accepted at t+1, with data at t+2 or later (cycle d): `*_resp_valid` at d+1.
- **Memory read latency:** any value ≥ 1 cycle after acceptance. `mem_resp_valid` in the acceptance cycle itself is ignored.
- **Back-to-back throughput:** a new request can be accepted in the cycle after RESP, i.e. once IDLE is reached. The minimum spacing is 4 cycles per read.
- **Simultaneous requests in IDLE:** exactly one grant; the loser's ready stays 0 and it keeps waiting.

## Configuration
- **`MEM_ARB_RR_EN` defined:**
  - Round-robin arbitration: on a tie, the requester that is not `last_owner` wins.
  - `last_owner` updates on every handshake.
  - Each requester gets at most one consecutive loss while the other is continuously valid.
- **`MEM_ARB_RR_EN` undefined:**
  - Fixed dcache priority; `last_owner` is not implemented.
  - A continuously valid dcache starves the icache, which is acceptable because the dcache stalls the pipeline.

## Structure
- **Package `mem_arbiter_pkg`:**
  - FSM state encoding (IDLE, ISSUE, WAIT, RESP).
  - Owner constants OWN_IC = 0 and OWN_DC = 1.
- **Sub-module `mem_arb_grant`:**
  - Combinational grant logic only.
  - Inputs: `ic_valid`, `dc_valid`, `last_owner`.
  - Outputs: `grant_ic`, `grant_dc`.
  - Holds the `MEM_ARB_RR_EN` selection.
- **Top level:** the FSM, payload and owner registers, and the response register.

## Test plan
- **icache read:**
  - Stimulus: `ic_req_valid` with addr 0x0000_1000; memory returns 0xDEAD_BEEF_0000_0001_0000_0002_0000_0003 two cycles after acceptance.
  - Required: `ic_resp_valid` pulses for 1 cycle with that data; `dc_resp_valid` stays 0; `busy` falls the cycle after.
- **dcache write:**
  - Stimulus: addr 0x0000_2000, we = 1, wdata 0x1234; `mem_req_ready` held low 3 cycles.
  - Required: `mem_req_*` stays stable across the stall; `dc_resp_valid` fires one cycle after the accept.
- **Simultaneous requests, macro undefined:** ic and dc both valid every cycle for 3 transactions → all 3 grants go to dcache.
- **Simultaneous requests, `MEM_ARB_RR_EN` defined:** ic and dc both valid every cycle → grants are DC, IC, DC, IC.
- **Reset in WAIT:**
  - Stimulus: assert `reset` during WAIT, then deliver `mem_resp_valid`.
  - Required: no `*_resp_valid`; `busy` = 0 immediately on reset.
- **Stray response:** `mem_resp_valid` in IDLE and in the acceptance cycle → ignored; the next request completes with the correct data.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for mem_arbiter: FSM state encoding and the owner identifiers
// used to route a completed transaction back to the requester that issued it.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and backing-memory handshakes around mem_arbiter.
// The arbiter connects through 'master' (it masters the memory port); the
// surrounding caches and memory model use 'slave'.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    logic              dc_req_valid;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_we;
    logic [DATA_W-1:0] dc_req_wdata;
    logic              dc_req_ready;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              busy;

    modport master (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_addr, dc_req_we, dc_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        output busy
    );

    modport slave (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_addr, dc_req_we, dc_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_grant.sv
// Combinational grant selection between icache and dcache requests.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise dcache always wins.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic   ic_valid,
    input  logic   dc_valid,
    input  owner_t last_owner,
    output logic   grant_ic,
    output logic   grant_dc
);

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win the previous handshake goes first.
    always_comb begin
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (ic_valid && dc_valid) begin
            grant_dc = (last_owner == OWN_IC);
            grant_ic = (last_owner == OWN_DC);
        end else begin
            grant_ic = ic_valid;
            grant_dc = dc_valid;
        end
    end
`else
    // Fixed priority has no history, so last_owner is deliberately left unread.
    owner_t unused_last_owner;
    assign unused_last_owner = last_owner;

    assign grant_dc = dc_valid;
    assign grant_ic = ic_valid & ~dc_valid;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single backing-memory port between icache refills and dcache
// refill/write-back, one transaction in flight. Define MEM_ARB_RR_EN for round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
)(
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master bus
);

    state_t            state;
    owner_t            owner;
    owner_t            last_owner;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] resp_data_q;
    logic              mem_req_valid_q;
    logic              ic_resp_valid_q;
    logic              dc_resp_valid_q;
    logic              busy_q;
    logic              grant_ic;
    logic              grant_dc;
    logic              idle;

    assign idle = (state == IDLE);

`ifdef MEM_ARB_RR_EN
    // The owner register only changes on a handshake, so it already is last_owner.
    assign last_owner = owner;
`else
    assign last_owner = OWN_IC;
`endif

    mem_arb_grant u_grant (
        .ic_valid   (bus.ic_req_valid),
        .dc_valid   (bus.dc_req_valid),
        .last_owner (last_owner),
        .grant_ic   (grant_ic),
        .grant_dc   (grant_dc)
    );

    assign bus.ic_req_ready  = idle & grant_ic;
    assign bus.dc_req_ready  = idle & grant_dc;
    assign bus.ic_resp_valid = ic_resp_valid_q;
    assign bus.dc_resp_valid = dc_resp_valid_q;
    assign bus.ic_resp_data  = resp_data_q;
    assign bus.dc_resp_data  = resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_we    = we_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.busy          = busy_q;

    // Transaction FSM; response pulses are raised on entry to RESP and
    // cleared by default so they last exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            owner           <= OWN_IC;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            ic_resp_valid_q <= 1'b0;
            dc_resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dc) begin
                        owner           <= OWN_DC;
                        addr_q          <= bus.dc_req_addr;
                        we_q            <= bus.dc_req_we;
                        wdata_q         <= bus.dc_req_wdata;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state           <= ISSUE;
                    end else if (grant_ic) begin
                        owner           <= OWN_IC;
                        addr_q          <= bus.ic_req_addr;
                        we_q            <= 1'b0;
                        wdata_q         <= '0;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (we_q) begin
                            ic_resp_valid_q <= (owner == OWN_IC);
                            dc_resp_valid_q <= (owner == OWN_DC);
                            state           <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_resp_valid) begin
                        resp_data_q     <= bus.mem_resp_data;
                        ic_resp_valid_q <= (owner == OWN_IC);
                        dc_resp_valid_q <= (owner == OWN_DC);
                        state           <= RESP;
                    end
                end
                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard testbench for mem_arbiter: expected responses are queued as requests
// are driven and matched against pulses seen by a monitor. Honours MEM_ARB_RR_EN.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam logic [127:0] IC_LINE = 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003;

    typedef struct {
        owner_t            owner;
        bit                is_write;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        owner_t            owner;
        bit                both;
        logic [DATA_W-1:0] data;
    } obs_t;

    logic   clk;
    logic   reset;
    int     tests_run;
    int     tests_failed;
    exp_t   exp_q[$];
    obs_t   obs_q[$];
    owner_t grant_q[$];
    obs_t   mon_obs;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: records response pulses and request handshakes at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ic_resp_valid || bus.dc_resp_valid) begin
                mon_obs.owner = bus.dc_resp_valid ? OWN_DC : OWN_IC;
                mon_obs.both  = bus.ic_resp_valid & bus.dc_resp_valid;
                mon_obs.data  = bus.dc_resp_valid ? bus.dc_resp_data : bus.ic_resp_data;
                obs_q.push_back(mon_obs);
            end
            if (bus.dc_req_valid && bus.dc_req_ready) grant_q.push_back(OWN_DC);
            if (bus.ic_req_valid && bus.ic_req_ready) grant_q.push_back(OWN_IC);
        end
    end

    function automatic logic [127:0] line_data(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd7};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input owner_t who, input bit is_write, input logic [127:0] data);
        exp_t e;
        e.owner    = who;
        e.is_write = is_write;
        e.data     = data;
        exp_q.push_back(e);
    endtask

    // Raise a request and hold it until the arbiter accepts it; returns one
    // cycle after the handshake edge with valid dropped.
    task automatic applyStimulus(input owner_t who, input logic [31:0] addr,
                                 input logic we, input logic [127:0] wdata);
        bit got = 1'b0;
        if (who == OWN_DC) begin
            bus.dc_req_addr  = addr;
            bus.dc_req_we    = we;
            bus.dc_req_wdata = wdata;
            bus.dc_req_valid = 1'b1;
        end else begin
            bus.ic_req_addr  = addr;
            bus.ic_req_valid = 1'b1;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            got = (who == OWN_DC) ? bus.dc_req_ready : bus.ic_req_ready;
            next_cycle();
        end
        if (who == OWN_DC) bus.dc_req_valid = 1'b0;
        else               bus.ic_req_valid = 1'b0;
        checkOutput("req_handshake", 256'(got), 256'(1));
    endtask

    task automatic wait_resp(input owner_t who);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            got = (who == OWN_DC) ? bus.dc_resp_valid : bus.ic_resp_valid;
            if (!got) next_cycle();
        end
        checkOutput("resp_wait", 256'(got), 256'(1));
    endtask

    // Memory model: checks the request fields across the stall, accepts, then
    // returns rdata 'lat' cycles later (lat = 0 means never respond).
    task automatic serve_mem(input int stall, input int lat, input bit stray,
                             input logic [31:0] e_addr, input logic e_we,
                             input logic [127:0] e_wdata, input logic [127:0] rdata);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.mem_req_valid) seen = 1'b1;
            else next_cycle();
        end
        checkOutput("mem_req_seen", 256'(seen), 256'(1));
        if (!seen) return;
        for (int s = 0; s <= stall; s++) begin
            checkOutput("mem_req_valid", 256'(bus.mem_req_valid), 256'(1));
            checkOutput("mem_req_addr", 256'(bus.mem_req_addr), 256'(e_addr));
            checkOutput("mem_req_we", 256'(bus.mem_req_we), 256'(e_we));
            if (e_we) checkOutput("mem_req_wdata", 256'(bus.mem_req_wdata), 256'(e_wdata));
            if (s < stall) next_cycle();
        end
        bus.mem_req_ready = 1'b1;
        if (stray) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = ~rdata;
        end
        next_cycle();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        if (!e_we && lat > 0) begin
            for (int l = 1; l < lat; l++) next_cycle();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = rdata;
            next_cycle();
            bus.mem_resp_valid = 1'b0;
        end
    endtask

    task automatic drain_scoreboard();
        exp_t e;
        obs_t o;
        checkOutput("resp_count", 256'(obs_q.size()), 256'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checkOutput("resp_owner", 256'(o.owner), 256'(e.owner));
            checkOutput("resp_single", 256'(o.both), 256'(0));
            if (!e.is_write) checkOutput("resp_data", 256'(o.data), 256'(e.data));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    owner_t exp_order[4];
    int     n_dc;
    int     n_ic;

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        reset              = 1'b1;
        bus.ic_req_valid   = 1'b0;
        bus.ic_req_addr    = '0;
        bus.dc_req_valid   = 1'b0;
        bus.dc_req_addr    = '0;
        bus.dc_req_we      = 1'b0;
        bus.dc_req_wdata   = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_busy", 256'(bus.busy), 256'(0));
        checkOutput("rst_mem_req_valid", 256'(bus.mem_req_valid), 256'(0));
        checkOutput("rst_mem_req_we", 256'(bus.mem_req_we), 256'(0));
        checkOutput("rst_mem_req_addr", 256'(bus.mem_req_addr), 256'(0));
        checkOutput("rst_resp_valid", 256'({bus.ic_resp_valid, bus.dc_resp_valid}), 256'(0));
        checkOutput("rst_resp_data", 256'(bus.ic_resp_data), 256'(0));
        reset = 1'b0;
        next_cycle();

        // icache read, data two cycles after acceptance
        push_exp(OWN_IC, 1'b0, IC_LINE);
        applyStimulus(OWN_IC, 32'h0000_1000, 1'b0, '0);
        checkOutput("ic_busy_issue", 256'(bus.busy), 256'(1));
        serve_mem(0, 2, 1'b0, 32'h0000_1000, 1'b0, '0, IC_LINE);
        checkOutput("ic_resp_valid", 256'(bus.ic_resp_valid), 256'(1));
        checkOutput("ic_no_dc_resp", 256'(bus.dc_resp_valid), 256'(0));
        checkOutput("ic_resp_data", 256'(bus.ic_resp_data), 256'(IC_LINE));
        next_cycle();
        checkOutput("ic_busy_after", 256'(bus.busy), 256'(0));
        checkOutput("ic_resp_single", 256'(bus.ic_resp_valid), 256'(0));
        drain_scoreboard();

        // dcache write with a three-cycle memory stall
        push_exp(OWN_DC, 1'b1, '0);
        applyStimulus(OWN_DC, 32'h0000_2000, 1'b1, 128'h1234);
        serve_mem(3, 0, 1'b0, 32'h0000_2000, 1'b1, 128'h1234, '0);
        checkOutput("dc_wr_resp", 256'(bus.dc_resp_valid), 256'(1));
        checkOutput("dc_wr_mem_drop", 256'(bus.mem_req_valid), 256'(0));
        next_cycle();
        checkOutput("dc_wr_idle", 256'(bus.busy), 256'(0));
        drain_scoreboard();

        // Both requesters continuously valid
`ifdef MEM_ARB_RR_EN
        exp_order = '{OWN_DC, OWN_IC, OWN_DC, OWN_IC};
        n_dc = 2;
        n_ic = 2;
`else
        exp_order = '{OWN_DC, OWN_DC, OWN_DC, OWN_IC};
        n_dc = 3;
        n_ic = 1;
`endif
        grant_q.delete();
        begin
            int dk = 0;
            int ik = 0;
            for (int i = 0; i < 4; i++) begin
                if (exp_order[i] == OWN_DC) begin
                    push_exp(OWN_DC, 1'b0, line_data(32'h3000 + 32'(16 * dk)));
                    dk++;
                end else begin
                    push_exp(OWN_IC, 1'b0, line_data(32'h4000 + 32'(16 * ik)));
                    ik++;
                end
            end
        end
        fork
            begin
                for (int k = 0; k < n_dc; k++) begin
                    applyStimulus(OWN_DC, 32'h3000 + 32'(16 * k), 1'b0, '0);
                    wait_resp(OWN_DC);
                end
            end
            begin
                for (int k = 0; k < n_ic; k++) begin
                    applyStimulus(OWN_IC, 32'h4000 + 32'(16 * k), 1'b0, '0);
                    wait_resp(OWN_IC);
                end
            end
            begin
                int dk = 0;
                int ik = 0;
                logic [31:0] a;
                for (int i = 0; i < 4; i++) begin
                    if (exp_order[i] == OWN_DC) begin
                        a = 32'h3000 + 32'(16 * dk);
                        dk++;
                    end else begin
                        a = 32'h4000 + 32'(16 * ik);
                        ik++;
                    end
                    serve_mem(0, 1, 1'b0, a, 1'b0, '0, line_data(a));
                end
            end
        join
        next_cycle();
        checkOutput("grant_count", 256'(grant_q.size()), 256'(4));
        for (int i = 0; i < 4 && i < grant_q.size(); i++)
            checkOutput("grant_order", 256'(grant_q[i]), 256'(exp_order[i]));
        drain_scoreboard();

        // Reset while waiting for read data, then a late memory response
        applyStimulus(OWN_DC, 32'h0000_6000, 1'b0, '0);
        serve_mem(0, 0, 1'b0, 32'h0000_6000, 1'b0, '0, '0);
        next_cycle();
        checkOutput("wait_busy", 256'(bus.busy), 256'(1));
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 256'(bus.busy), 256'(0));
        checkOutput("abort_mem_req", 256'(bus.mem_req_valid), 256'(0));
        next_cycle();
        reset              = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'hBAD0_BAD0;
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        next_cycle();
        checkOutput("late_resp_busy", 256'(bus.busy), 256'(0));
        checkOutput("late_resp_valid", 256'({bus.ic_resp_valid, bus.dc_resp_valid}), 256'(0));
        push_exp(OWN_DC, 1'b0, line_data(32'h7000));
        applyStimulus(OWN_DC, 32'h0000_7000, 1'b0, '0);
        serve_mem(0, 1, 1'b0, 32'h0000_7000, 1'b0, '0, line_data(32'h7000));
        next_cycle();
        drain_scoreboard();

        // Stray responses in IDLE and in the acceptance cycle
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 128'hFFFF_0000;
        next_cycle();
        bus.mem_resp_valid = 1'b0;
        checkOutput("stray_idle_busy", 256'(bus.busy), 256'(0));
        push_exp(OWN_IC, 1'b0, line_data(32'h5000));
        applyStimulus(OWN_IC, 32'h0000_5000, 1'b0, '0);
        serve_mem(0, 3, 1'b1, 32'h0000_5000, 1'b0, '0, line_data(32'h5000));
        checkOutput("stray_resp_data", 256'(bus.ic_resp_data), 256'(line_data(32'h5000)));
        next_cycle();
        drain_scoreboard();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
